// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius memory-game sequencer.
// Holds the FSM state enum, highlight codes and key/colour helpers.
package genius_pkg;

  localparam int MAX_LEN = 32;
  localparam int IDX_W   = 6;

  typedef enum logic [2:0] {
    IDLE,
    SHOW_ON,
    SHOW_OFF,
    WAIT_KEY,
    ECHO,
    PASS,
    FAIL
  } state_t;

  localparam logic [3:0] CODE_NONE   = 4'b0000;
  localparam logic [3:0] CODE_RED    = 4'b0001;
  localparam logic [3:0] CODE_GREEN  = 4'b0010;
  localparam logic [3:0] CODE_YELLOW = 4'b0011;
  localparam logic [3:0] CODE_BLUE   = 4'b0100;

  function automatic logic [3:0] color_code(input logic [1:0] c);
    case (c)
      2'd0:    return CODE_RED;
      2'd1:    return CODE_GREEN;
      2'd2:    return CODE_YELLOW;
      default: return CODE_BLUE;
    endcase
  endfunction

  function automatic logic key_onehot(input logic [3:0] k);
    return (k != 4'd0) && ((k & (k - 4'd1)) == 4'd0);
  endfunction

  // Only meaningful for one-hot keys.
  function automatic logic [1:0] key_color(input logic [3:0] k);
    case (k)
      4'b0001: return 2'd0;
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick from the active-low VGA vertical sync: a one-cycle pulse
// one cycle after a registered falling edge of vs_n.
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic vs_n,
  output logic tick
);

  logic vs_q, vs_dly_q, tick_q;
  logic tick_d;

  always_comb tick_d = vs_dly_q & ~vs_q;

  // Sync history resets high (sync idle) so reset release never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q     <= 1'b1;
      vs_dly_q <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      vs_q     <= vs_n;
      vs_dly_q <= vs_q;
      tick_q   <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/genius_sequencer.sv
// Genius (Simon) round sequencer: plays a stored colour sequence frame-timed
// off VGA vsync, then checks the player's key presses against it.
module genius_sequencer
  import genius_pkg::*;
#(
  parameter int ON_FRAMES      = 30,
  parameter int OFF_FRAMES     = 15,
  parameter int TIMEOUT_FRAMES = 300
) (
  input  logic       iVGA_CLK,
  input  logic       iRST,
  input  logic       iVS,
  input  logic       iWrEn,
  input  logic [4:0] iWrAddr,
  input  logic [1:0] iWrColor,
  input  logic       iStart,
  input  logic [5:0] iLen,
  input  logic [3:0] iKey,
  output logic [3:0] oCodeColor,
  output logic       oBusy,
  output logic       oPass,
  output logic       oFail
);

  localparam int CNT_W = $clog2(max3(ON_FRAMES, OFF_FRAMES, TIMEOUT_FRAMES) + 1);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_FRAMES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_FRAMES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_FRAMES - 1);

  logic tick;

  frame_tick_gen u_tick (
    .clk  (iVGA_CLK),
    .rst  (iRST),
    .vs_n (iVS),
    .tick (tick)
  );

  // Sequence memory survives reset on purpose: the host loads it once.
  logic [1:0] mem_q [MAX_LEN];

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, len_q, len_d, idx_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       echo_q, echo_d;
  logic [3:0]       code_q, code_d;
  logic             busy_q, busy_d, pass_q, pass_d, fail_q, fail_d;

  always_ff @(posedge iVGA_CLK) begin
    if (iWrEn && state_q == IDLE) mem_q[iWrAddr] <= iWrColor;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    echo_d  = echo_q;
    idx_inc = idx_q + IDX_W'(1);

    case (state_q)
      IDLE: begin
        if (iStart && iLen != 6'd0) begin
          len_d   = (iLen > 6'(MAX_LEN)) ? 6'(MAX_LEN) : iLen;
          idx_d   = '0;
          state_d = SHOW_ON;
        end
      end
      SHOW_ON: begin
        if (tick && cnt_q == ON_LAST) state_d = SHOW_OFF;
      end
      SHOW_OFF: begin
        if (tick && cnt_q == OFF_LAST) begin
          if (idx_inc < len_q) begin
            idx_d   = idx_inc;
            state_d = SHOW_ON;
          end else begin
            idx_d   = '0;
            state_d = WAIT_KEY;
          end
        end
      end
      WAIT_KEY: begin
        // A key press wins over a coincident timeout tick.
        if (iKey != 4'd0) begin
          if (key_onehot(iKey) && key_color(iKey) == mem_q[idx_q[4:0]]) begin
            echo_d  = key_color(iKey);
            state_d = ECHO;
          end else begin
            state_d = FAIL;
          end
        end else if (tick && cnt_q == TO_LAST) begin
          state_d = FAIL;
        end
      end
      ECHO: begin
        if (tick && cnt_q == ON_LAST) begin
          idx_d   = idx_inc;
          state_d = (idx_inc == len_q) ? PASS : WAIT_KEY;
        end
      end
      PASS:    state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame counter restarts on every state entry, including ECHO -> WAIT_KEY.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (tick && (state_q == SHOW_ON || state_q == SHOW_OFF ||
                          state_q == WAIT_KEY || state_q == ECHO)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    code_d = CODE_NONE;
    case (state_d)
      SHOW_ON: code_d = color_code(mem_q[idx_d[4:0]]);
      ECHO:    code_d = color_code(echo_d);
      default: code_d = CODE_NONE;
    endcase
    busy_d = (state_d != IDLE);
    pass_d = (state_d == PASS);
    fail_d = (state_d == FAIL);
  end

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      echo_q  <= '0;
      code_q  <= CODE_NONE;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      echo_q  <= echo_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign oCodeColor = code_q;
  assign oBusy      = busy_q;
  assign oPass      = pass_q;
  assign oFail      = fail_q;

endmodule

// File: tb/tb_genius_sequencer.sv
// Bench for genius_sequencer: scenario tasks compared against a frame-level
// model of what the player should see (per-frame colour list, key outcomes).
module tb_genius_sequencer;

  localparam int ON  = 2;
  localparam int OFF = 1;
  localparam int TO  = 3;

  logic       iVGA_CLK = 1'b0;
  logic       iRST     = 1'b1;
  logic       iVS      = 1'b1;
  logic       iWrEn    = 1'b0;
  logic [4:0] iWrAddr  = '0;
  logic [1:0] iWrColor = '0;
  logic       iStart   = 1'b0;
  logic [5:0] iLen     = '0;
  logic [3:0] iKey     = '0;
  logic [3:0] oCodeColor;
  logic       oBusy, oPass, oFail;

  genius_sequencer #(.ON_FRAMES(ON), .OFF_FRAMES(OFF), .TIMEOUT_FRAMES(TO)) dut (
    .iVGA_CLK   (iVGA_CLK),
    .iRST       (iRST),
    .iVS        (iVS),
    .iWrEn      (iWrEn),
    .iWrAddr    (iWrAddr),
    .iWrColor   (iWrColor),
    .iStart     (iStart),
    .iLen       (iLen),
    .iKey       (iKey),
    .oCodeColor (oCodeColor),
    .oBusy      (oBusy),
    .oPass      (oPass),
    .oFail      (oFail)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  logic [1:0] mdl_mem [32];
  logic [3:0] obs [$];
  logic [3:0] exp_q [$];

  always @(negedge iVGA_CLK) begin
    if (oPass) pass_cnt++;
    if (oFail) fail_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [3:0] code_of(input int c);
    return 4'(c + 1);
  endfunction

  // What the screen shows after the start and after each frame of playback.
  function automatic void build_expected(input int len);
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      for (int f = 0; f < ON; f++) exp_q.push_back(code_of(int'(mdl_mem[i])));
      for (int f = 0; f < OFF; f++) exp_q.push_back(4'd0);
    end
    exp_q.push_back(4'd0);
  endfunction

  task automatic cyc();
    @(posedge iVGA_CLK);
    #1;
  endtask

  task automatic frame();
    iVS = 1'b0;
    cyc(); cyc();
    iVS = 1'b1;
    repeat (4) cyc();
  endtask

  task automatic wr(input int a, input int c, input bit taken);
    iWrEn = 1'b1; iWrAddr = 5'(a); iWrColor = 2'(c);
    cyc();
    iWrEn = 1'b0;
    if (taken) mdl_mem[a] = 2'(c);
  endtask

  task automatic start_round(input int len);
    iLen = 6'(len); iStart = 1'b1;
    cyc();
    iStart = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    iKey = k;
    cyc();
    iKey = 4'd0;
  endtask

  task automatic run_playback(input int nframes);
    obs.delete();
    obs.push_back(oCodeColor);
    for (int f = 0; f < nframes; f++) begin
      frame();
      obs.push_back(oCodeColor);
    end
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    repeat (3) cyc();
    n_cmp++;
    if ({oCodeColor, oBusy, oPass, oFail} !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 0000000", {oCodeColor, oBusy, oPass, oFail});
    end
    iRST = 1'b0;
    cyc();
  endtask

  task automatic test_playback();
    wr(0, 0, 1'b1);
    wr(1, 3, 1'b1);
    start_round(2);
    run_playback(2 * (ON + OFF));
    build_expected(2);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL playback[%0d]: got %b want %b", i, obs[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (oBusy !== 1'b1) begin
      n_bad++;
      $display("FAIL playback_busy: got %b want 1", oBusy);
    end
  endtask

  task automatic test_echo_pass();
    logic [3:0] keys [2];
    int p0;
    keys[0] = 4'b0001; keys[1] = 4'b1000;
    p0 = pass_cnt;
    for (int k = 0; k < 2; k++) begin
      press(keys[k]);
      for (int f = 1; f <= ON; f++) begin
        n_cmp++;
        if (oCodeColor !== code_of(int'(mdl_mem[k]))) begin
          n_bad++;
          $display("FAIL echo%0d_code: got %b want %b", k, oCodeColor, code_of(int'(mdl_mem[k])));
        end
        frame();
      end
    end
    n_cmp++;
    if (pass_cnt - p0 !== 1) begin
      n_bad++;
      $display("FAIL pass_pulse_cycles: got %0d want 1", pass_cnt - p0);
    end
    n_cmp++;
    if ({oBusy, oCodeColor, oFail} !== 6'd0) begin
      n_bad++;
      $display("FAIL pass_idle: got busy=%b code=%b fail=%b want 0", oBusy, oCodeColor, oFail);
    end
  endtask

  task automatic test_wrong_key();
    logic [3:0] bad [2];
    bad[0] = 4'b0010; bad[1] = 4'b0011;
    for (int t = 0; t < 2; t++) begin
      start_round(2);
      run_playback(2 * (ON + OFF));
      press(bad[t]);
      n_cmp++;
      if (oFail !== 1'b1 || oCodeColor !== 4'd0) begin
        n_bad++;
        $display("FAIL wrong_key%0d: got fail=%b code=%b want fail=1 code=0000", t, oFail, oCodeColor);
      end
      cyc();
      n_cmp++;
      if (oFail !== 1'b0 || oBusy !== 1'b0) begin
        n_bad++;
        $display("FAIL wrong_key%0d_after: got fail=%b busy=%b want 0 0", t, oFail, oBusy);
      end
    end
  endtask

  task automatic test_timeout();
    start_round(2);
    run_playback(2 * (ON + OFF));
    for (int f = 0; f < TO - 1; f++) frame();
    n_cmp++;
    if (oBusy !== 1'b1 || oFail !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_early: got busy=%b fail=%b want 1 0", oBusy, oFail);
    end
    iVS = 1'b0;
    cyc(); cyc();
    iVS = 1'b1;
    n_cmp++;
    if (oFail !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_before_tick: got %b want 0", oFail);
    end
    cyc();
    n_cmp++;
    if (oFail !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_fail: got %b want 1", oFail);
    end
    cyc();
    n_cmp++;
    if (oFail !== 1'b0 || oBusy !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_after: got fail=%b busy=%b want 0 0", oFail, oBusy);
    end
    repeat (2) cyc();
  endtask

  task automatic test_len_bounds();
    start_round(0);
    n_cmp++;
    if (oBusy !== 1'b0) begin
      n_bad++;
      $display("FAIL len0_ignored: got busy=%b want 0", oBusy);
    end
    // Start a 2-colour round, then try to overwrite mem[1] mid-playback.
    wr(0, 0, 1'b1);
    wr(1, 3, 1'b1);
    start_round(2);
    wr(1, 1, 1'b0);
    run_playback(2 * (ON + OFF));
    build_expected(2);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL wr_ignored[%0d]: got %b want %b", i, obs[i], exp_q[i]);
      end
    end
    press(4'b0011);
    cyc();
    for (int a = 0; a < 32; a++) wr(a, int'($urandom_range(0, 3)), 1'b1);
    start_round(40);
    run_playback(32 * (ON + OFF));
    build_expected(32);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL len40[%0d]: got %b want %b", i, obs[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (oBusy !== 1'b1) begin
      n_bad++;
      $display("FAIL len40_wait: got busy=%b want 1", oBusy);
    end
    press(4'b0011);
    cyc();
  endtask

  task automatic test_reset_mid();
    wr(0, 0, 1'b1);
    wr(1, 3, 1'b1);
    start_round(2);
    frame();
    #1 iRST = 1'b1;
    #1;
    n_cmp++;
    if ({oCodeColor, oBusy, oPass, oFail} !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_async: got %b want 0000000", {oCodeColor, oBusy, oPass, oFail});
    end
    cyc();
    iRST = 1'b0;
    cyc();
    start_round(2);
    run_playback(2 * (ON + OFF));
    build_expected(2);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL replay[%0d]: got %b want %b", i, obs[i], exp_q[i]);
      end
    end
    press(4'b0100);
    cyc();
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int len, fail_at, p0, f0;
      logic [3:0] k;
      for (int a = 0; a < 32; a++) wr(a, int'($urandom_range(0, 3)), 1'b1);
      len = int'($urandom_range(1, 6));
      fail_at = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, len - 1));
      p0 = pass_cnt; f0 = fail_cnt;
      start_round(len);
      run_playback(len * (ON + OFF));
      build_expected(len);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (obs[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL rnd%0d_play[%0d]: got %b want %b", r, i, obs[i], exp_q[i]);
        end
      end
      for (int i = 0; i < len; i++) begin
        if (i == fail_at) begin
          do k = 4'($urandom_range(1, 15)); while (k == (4'd1 << mdl_mem[i]));
          press(k);
          n_cmp++;
          if (oFail !== 1'b1) begin
            n_bad++;
            $display("FAIL rnd%0d_badkey: key=%b got fail=%b want 1", r, k, oFail);
          end
          break;
        end
        press(4'd1 << mdl_mem[i]);
        n_cmp++;
        if (oCodeColor !== code_of(int'(mdl_mem[i]))) begin
          n_bad++;
          $display("FAIL rnd%0d_echo[%0d]: got %b want %b", r, i, oCodeColor, code_of(int'(mdl_mem[i])));
        end
        for (int f = 0; f < ON; f++) frame();
      end
      cyc();
      n_cmp++;
      if (pass_cnt - p0 !== (fail_at < 0 ? 1 : 0) || fail_cnt - f0 !== (fail_at < 0 ? 0 : 1)
          || oBusy !== 1'b0) begin
        n_bad++;
        $display("FAIL rnd%0d_outcome: got pass=%0d fail=%0d busy=%b want pass=%0d fail=%0d busy=0",
                 r, pass_cnt - p0, fail_cnt - f0, oBusy, (fail_at < 0 ? 1 : 0), (fail_at < 0 ? 0 : 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_playback();
    test_echo_pass();
    test_wrong_key();
    test_timeout();
    test_len_bounds();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
